accu_frame: RTL and testbench

- Parameterised frame accumulator. Sums every N consecutive accepted input samples and emits one result per frame.
- Handshake is valid/ready on both sides, so the output can be backpressured.
- A flush input closes a partial frame early.
- Supports signed or unsigned samples.
- Sits between a sample source and downstream consumers, e.g. a decimation or averaging stage.

---
 rtl/accu_frame.sv | 85 ++++++++
 tb/tb_accu_frame.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accu_frame.sv
// Frame accumulator: sums every N accepted samples, or fewer when flushed, and
// emits one result per frame over a valid/ready output that can be backpressured.
module accu_frame #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int SIGNED = 0,
  parameter int OUT_W  = DATA_W + $clog2(N),
  parameter int CNT_W  = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              flush_in,
  output logic [OUT_W-1:0]  data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [CNT_W-1:0]  num_out
);

  logic [OUT_W-1:0] acc_reg;
  logic [OUT_W-1:0] data_out_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] num_out_reg;
  logic             valid_out_reg;

  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] s_val;
  logic [OUT_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_plus;
  logic             beat;
  logic             full_emit;
  logic             flush_emit;
  logic             emit;

  generate
    if (SIGNED != 0) begin : g_sext
      assign ext_data = {{(OUT_W-DATA_W){data_in[DATA_W-1]}}, data_in};
    end else begin : g_zext
      assign ext_data = {{(OUT_W-DATA_W){1'b0}}, data_in};
    end
  endgenerate

  // Output slot is free when empty or being drained this same cycle.
  assign ready_in = !valid_out_reg || ready_out;
  assign beat     = valid_in && ready_in;

  // acc is not cleared on emit; cnt==0 marks it as stale instead.
  assign s_val    = (cnt_reg == '0) ? '0 : acc_reg;
  assign sum_next = s_val + (beat ? ext_data : '0);
  assign cnt_plus = cnt_reg + CNT_W'(beat);

  assign full_emit  = beat && (cnt_reg == CNT_W'(N - 1));
  assign flush_emit = ready_in && flush_in && ((cnt_reg != '0) || beat);
  assign emit       = full_emit || flush_emit;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      data_out_reg  <= '0;
      num_out_reg   <= '0;
      valid_out_reg <= 1'b0;
    end else if (emit) begin
      data_out_reg  <= sum_next;
      num_out_reg   <= cnt_plus;
      valid_out_reg <= 1'b1;
      cnt_reg       <= '0;
    end else begin
      if (valid_out_reg && ready_out) begin
        valid_out_reg <= 1'b0;
      end
      if (beat) begin
        acc_reg <= sum_next;
        cnt_reg <= cnt_plus;
      end
    end
  end

  assign data_out  = data_out_reg;
  assign num_out   = num_out_reg;
  assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_accu_frame.sv
// Directed bench for accu_frame: an unsigned and a signed instance, expected
// results queued at stimulus time and compared when each result is taken.
module tb_accu_frame;

  typedef struct packed {
    logic [9:0] d;
    logic [2:0] n;
  } exp_t;

  logic       clk;
  logic       rst;

  logic [7:0] data0;
  logic       valid0, flush0, ready_out0;
  logic       ready_in0, valid_out0;
  logic [9:0] data_out0;
  logic [2:0] num_out0;

  logic [7:0] data1;
  logic       valid1, flush1, ready_out1;
  logic       ready_in1, valid_out1;
  logic [9:0] data_out1;
  logic [2:0] num_out1;

  exp_t q0[$];
  exp_t q1[$];

  int n_vec;
  int n_err;

  accu_frame #(.DATA_W(8), .N(4), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(data0), .valid_in(valid0), .ready_in(ready_in0),
    .flush_in(flush0), .data_out(data_out0), .valid_out(valid_out0),
    .ready_out(ready_out0), .num_out(num_out0)
  );

  accu_frame #(.DATA_W(8), .N(4), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data1), .valid_in(valid1), .ready_in(ready_in1),
    .flush_in(flush1), .data_out(data_out1), .valid_out(valid_out1),
    .ready_out(ready_out1), .num_out(num_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (valid_out0 && ready_out0) begin
      if (q0.size() == 0) chk("u0_unexpected_valid", 32'(valid_out0), 32'd0);
      else begin
        e = q0.pop_front();
        chk("u0_data", 32'(data_out0), 32'(e.d));
        chk("u0_num", 32'(num_out0), 32'(e.n));
      end
    end
    if (valid_out1 && ready_out1) begin
      if (q1.size() == 0) chk("u1_unexpected_valid", 32'(valid_out1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("u1_data", 32'(data_out1), 32'(e.d));
        chk("u1_num", 32'(num_out1), 32'(e.n));
      end
    end
  endtask

  // One clock: observe at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [7:0] d, input logic f);
    valid0 = v;
    data0  = d;
    flush0 = f;
    tick();
    valid0 = 1'b0;
    flush0 = 1'b0;
  endtask

  task automatic drive1(input logic [7:0] d);
    valid1 = 1'b1;
    data1  = d;
    tick();
    valid1 = 1'b0;
  endtask

  initial begin
    int unsigned sum;
    logic [7:0] d;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    data0 = '0; valid0 = 1'b0; flush0 = 1'b0; ready_out0 = 1'b1;
    data1 = '0; valid1 = 1'b0; flush1 = 1'b0; ready_out1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_valid_out", 32'(valid_out0), 32'd0);
    chk("reset_data_out", 32'(data_out0), 32'd0);
    chk("reset_num_out", 32'(num_out0), 32'd0);
    chk("reset_ready_in", 32'(ready_in0), 32'd1);

    // Basic frame, one-cycle latency, single-cycle valid
    drive0(1, 8'd10, 0);
    drive0(1, 8'd20, 0);
    drive0(1, 8'd30, 0);
    q0.push_back('{d: 10'd100, n: 3'd4});
    drive0(1, 8'd40, 0);
    chk("t1_latency_valid", 32'(valid_out0), 32'd1);
    tick();
    chk("t1_valid_drop", 32'(valid_out0), 32'd0);

    // Full-scale back-to-back frames
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 7) q0.push_back('{d: 10'h3FC, n: 3'd4});
      drive0(1, 8'd255, 0);
    end
    tick();

    // Backpressure: result held, input stalled
    ready_out0 = 1'b0;
    drive0(1, 8'd1, 0);
    drive0(1, 8'd2, 0);
    drive0(1, 8'd3, 0);
    q0.push_back('{d: 10'd10, n: 3'd4});
    drive0(1, 8'd4, 0);
    for (int i = 0; i < 5; i++) begin
      valid0 = 1'b1;
      data0  = 8'd99;
      chk("bp_ready_in", 32'(ready_in0), 32'd0);
      chk("bp_data_hold", 32'(data_out0), 32'd10);
      chk("bp_valid_hold", 32'(valid_out0), 32'd1);
      tick();
    end
    valid0 = 1'b0;
    ready_out0 = 1'b1;
    tick();
    drive0(1, 8'd5, 0);
    drive0(1, 8'd6, 0);
    drive0(1, 8'd7, 0);
    q0.push_back('{d: 10'd26, n: 3'd4});
    drive0(1, 8'd8, 0);
    tick();

    // Flush on idle cycle, flush with a sample, flush with nothing pending
    drive0(1, 8'd5, 0);
    drive0(1, 8'd7, 0);
    q0.push_back('{d: 10'd12, n: 3'd2});
    drive0(0, 8'd0, 1);
    drive0(1, 8'd5, 0);
    drive0(1, 8'd7, 0);
    q0.push_back('{d: 10'd21, n: 3'd3});
    drive0(1, 8'd9, 1);
    drive0(0, 8'd0, 1);
    chk("idle_flush_no_valid", 32'(valid_out0), 32'd0);
    tick();
    chk("idle_flush_still_no_valid", 32'(valid_out0), 32'd0);

    // Flush coinciding with the N-th sample gives a single full result
    drive0(1, 8'd1, 0);
    drive0(1, 8'd1, 0);
    drive0(1, 8'd1, 0);
    q0.push_back('{d: 10'd4, n: 3'd4});
    drive0(1, 8'd1, 1);
    tick();
    chk("flush_nth_single", 32'(valid_out0), 32'd0);

    // Signed instance
    drive1(8'h80);
    drive1(8'h80);
    drive1(8'h80);
    q1.push_back('{d: 10'h200, n: 3'd4});
    drive1(8'h80);
    drive1(8'd127);
    drive1(8'hFF);
    drive1(8'hFF);
    q1.push_back('{d: 10'd130, n: 3'd4});
    drive1(8'd5);
    tick();

    // Reset mid-frame discards the partial sum
    drive0(1, 8'd3, 0);
    drive0(1, 8'd4, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive0(1, 8'd1, 0);
    drive0(1, 8'd1, 0);
    drive0(1, 8'd1, 0);
    q0.push_back('{d: 10'd4, n: 3'd4});
    drive0(1, 8'd1, 0);
    tick();

    // Reset while a result is held under backpressure
    ready_out0 = 1'b0;
    for (int i = 0; i < 4; i++) drive0(1, 8'd2, 0);
    chk("rst_hold_valid", 32'(valid_out0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_valid", 32'(valid_out0), 32'd0);
    chk("rst_clears_data", 32'(data_out0), 32'd0);
    chk("rst_clears_num", 32'(num_out0), 32'd0);
    ready_out0 = 1'b1;

    // Random unsigned frames, expected sums computed here
    for (int f = 0; f < 6; f++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        d = 8'($urandom_range(0, 255));
        sum += d;
        if (i == 3) q0.push_back('{d: 10'(sum), n: 3'd4});
        drive0(1, d, 0);
      end
    end

    repeat (3) tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
